// File: rtl/cycle_sequencer_if.sv
// Phase, resume, RAM and status signals between the sequencer (master) and its
// environment: clock stage, RAM and execute unit (slave).
interface cycle_sequencer_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
);
   logic              cycle_clk;
   logic              ram_clk;
   logic              internal_clk;
   logic              resume;
   logic [DATA_W-1:0] ram_rdata;
   logic [ADDR_W-1:0] ram_addr;
   logic              ram_rd;
   logic              exec_strobe;
   logic [DATA_W-1:0] ir;
   logic [ADDR_W-1:0] pc;
   logic [1:0]        state;
   logic              halt;
   logic [7:0]        instr_count;

   modport master (
      input  cycle_clk, ram_clk, internal_clk, resume, ram_rdata,
      output ram_addr, ram_rd, exec_strobe, ir, pc, state, halt, instr_count
   );

   modport slave (
      output cycle_clk, ram_clk, internal_clk, resume, ram_rdata,
      input  ram_addr, ram_rd, exec_strobe, ir, pc, state, halt, instr_count
   );
endinterface

// File: rtl/cycle_sequencer.sv
// Fetch/decode/execute/writeback control stage stepped by the three clock-stage
// phase pulses; owns pc, ir and the RAM read strobe, and raises halt on HALT.
module cycle_sequencer #(
   parameter int                 ADDR_W   = 8,
   parameter int                 DATA_W   = 8,
   parameter int                 OPC_W    = 4,
   parameter logic [OPC_W-1:0]   HALT_OPC = 4'hF,
   parameter logic [OPC_W-1:0]   JMP_OPC  = 4'h1,
   parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
   input logic clk,
   input logic reset,
   cycle_sequencer_if.master bus
);

   typedef enum logic [1:0] {FETCH, DECODE, EXECUTE, WRITEBACK} state_t;

   state_t            state_q, state_n;
   logic [ADDR_W-1:0] pc_q, pc_n, addr_q, addr_n;
   logic [DATA_W-1:0] ir_q, ir_n;
   logic [7:0]        cnt_q, cnt_n;
   logic              halt_q, halt_n, rd_q, rd_n, ex_q, ex_n;
   logic              ev_cyc, ev_ram, ev_int;
   logic [OPC_W-1:0]  opcode;
   logic [DATA_W-OPC_W-1:0] operand;

   assign opcode  = ir_q[DATA_W-1 -: OPC_W];
   assign operand = ir_q[DATA_W-OPC_W-1:0];

   // Only the highest-priority phase counts, and nothing counts while halted.
   assign ev_int = bus.internal_clk & ~halt_q;
   assign ev_ram = bus.ram_clk & ~bus.internal_clk & ~halt_q;
   assign ev_cyc = bus.cycle_clk & ~bus.ram_clk & ~bus.internal_clk & ~halt_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= FETCH;
         pc_q    <= RESET_PC;
         addr_q  <= '0;
         ir_q    <= '0;
         cnt_q   <= '0;
         halt_q  <= 1'b0;
         rd_q    <= 1'b0;
         ex_q    <= 1'b0;
      end else begin
         state_q <= state_n;
         pc_q    <= pc_n;
         addr_q  <= addr_n;
         ir_q    <= ir_n;
         cnt_q   <= cnt_n;
         halt_q  <= halt_n;
         rd_q    <= rd_n;
         ex_q    <= ex_n;
      end
   end

   always_comb begin
      state_n = state_q;
      pc_n    = pc_q;
      addr_n  = addr_q;
      ir_n    = ir_q;
      cnt_n   = cnt_q;
      halt_n  = halt_q;
      rd_n    = 1'b0;   // strobes are single-cycle pulses
      ex_n    = 1'b0;
      case (state_q)
         FETCH: begin
            if (ev_cyc) addr_n = pc_q;
            if (ev_ram) rd_n = 1'b1;
            if (ev_int) begin
               ir_n    = bus.ram_rdata;
               pc_n    = pc_q + ADDR_W'(1);
               state_n = DECODE;
            end
         end
         DECODE: begin
            if (ev_int) begin
               if (opcode == HALT_OPC) begin
                  halt_n  = 1'b1;
                  state_n = FETCH;
                  cnt_n   = cnt_q + 8'd1;
               end else begin
                  state_n = EXECUTE;
               end
            end
         end
         EXECUTE: begin
            if (ev_ram) ex_n = 1'b1;
            if (ev_int) begin
               if (opcode == JMP_OPC) pc_n = ADDR_W'(operand);
               state_n = WRITEBACK;
            end
         end
         WRITEBACK: begin
            if (ev_int) begin
               state_n = FETCH;
               cnt_n   = cnt_q + 8'd1;
            end
         end
         default: state_n = FETCH;
      endcase
      if (halt_q && bus.resume) begin
         halt_n  = 1'b0;
         state_n = FETCH;
      end
   end

   assign bus.ram_addr    = addr_q;
   assign bus.ram_rd      = rd_q;
   assign bus.exec_strobe = ex_q;
   assign bus.ir          = ir_q;
   assign bus.pc          = pc_q;
   assign bus.state       = state_q;
   assign bus.halt        = halt_q;
   assign bus.instr_count = cnt_q;

endmodule

// File: tb/tb_cycle_sequencer.sv
// Directed bench for cycle_sequencer: a table of machine-cycle expectations
// for a NOP/NOP/NOP/JMP program, plus hand sequences for halt, resume and reset.
module tb_cycle_sequencer;
   logic clk = 1'b0;
   logic reset = 1'b0;
   logic cyc = 1'b0, rmc = 1'b0, inc = 1'b0, res = 1'b0;
   logic [7:0] mem [256];
   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   cycle_sequencer_if #(.ADDR_W(8), .DATA_W(8)) ifa ();
   cycle_sequencer_if #(.ADDR_W(8), .DATA_W(8)) ifb ();

   assign ifa.cycle_clk    = cyc;
   assign ifa.ram_clk      = rmc;
   assign ifa.internal_clk = inc;
   assign ifa.resume       = res;
   assign ifa.ram_rdata    = mem[ifa.ram_addr];
   assign ifb.cycle_clk    = cyc;
   assign ifb.ram_clk      = rmc;
   assign ifb.internal_clk = inc;
   assign ifb.resume       = res;
   assign ifb.ram_rdata    = mem[ifb.ram_addr];

   cycle_sequencer #(.RESET_PC(8'h00)) dut_a (.clk(clk), .reset(reset), .bus(ifa));
   cycle_sequencer #(.RESET_PC(8'hFF)) dut_b (.clk(clk), .reset(reset), .bus(ifb));

   typedef struct packed {
      logic [1:0] st;
      logic [7:0] pc;
      logic [7:0] cnt;
      logic [7:0] addr;
      logic       rd;
      logic       ex;
   } row_t;

   row_t tbl [17];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse(input logic c, input logic r, input logic i, input logic s);
      cyc = c; rmc = r; inc = i; res = s;
      step();
      cyc = 1'b0; rmc = 1'b0; inc = 1'b0; res = 1'b0;
   endtask

   // One cycle_clk/ram_clk/internal_clk triple; reports the strobes seen while
   // internal_clk is being driven.
   task automatic machine_cycle(output logic rd_seen, output logic ex_seen);
      pulse(1, 0, 0, 0);
      pulse(0, 1, 0, 0);
      rd_seen = ifa.ram_rd;
      ex_seen = ifa.exec_strobe;
      pulse(0, 0, 1, 0);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      step();
      step();
      reset = 1'b1;
   endtask

   initial begin
      logic rd_s, ex_s;
      for (int k = 0; k < 256; k++) mem[k] = 8'h00;
      mem[3] = 8'h1A;

      tbl[0]  = '{2'd1, 8'h01, 8'h00, 8'h00, 1'b1, 1'b0};
      tbl[1]  = '{2'd2, 8'h01, 8'h00, 8'h00, 1'b0, 1'b0};
      tbl[2]  = '{2'd3, 8'h01, 8'h00, 8'h00, 1'b0, 1'b1};
      tbl[3]  = '{2'd0, 8'h01, 8'h01, 8'h00, 1'b0, 1'b0};
      tbl[4]  = '{2'd1, 8'h02, 8'h01, 8'h01, 1'b1, 1'b0};
      tbl[5]  = '{2'd2, 8'h02, 8'h01, 8'h01, 1'b0, 1'b0};
      tbl[6]  = '{2'd3, 8'h02, 8'h01, 8'h01, 1'b0, 1'b1};
      tbl[7]  = '{2'd0, 8'h02, 8'h02, 8'h01, 1'b0, 1'b0};
      tbl[8]  = '{2'd1, 8'h03, 8'h02, 8'h02, 1'b1, 1'b0};
      tbl[9]  = '{2'd2, 8'h03, 8'h02, 8'h02, 1'b0, 1'b0};
      tbl[10] = '{2'd3, 8'h03, 8'h02, 8'h02, 1'b0, 1'b1};
      tbl[11] = '{2'd0, 8'h03, 8'h03, 8'h02, 1'b0, 1'b0};
      tbl[12] = '{2'd1, 8'h04, 8'h03, 8'h03, 1'b1, 1'b0};
      tbl[13] = '{2'd2, 8'h04, 8'h03, 8'h03, 1'b0, 1'b0};
      tbl[14] = '{2'd3, 8'h0A, 8'h03, 8'h03, 1'b0, 1'b1};
      tbl[15] = '{2'd0, 8'h0A, 8'h04, 8'h03, 1'b0, 1'b0};
      tbl[16] = '{2'd1, 8'h0B, 8'h04, 8'h0A, 1'b1, 1'b0};

      // reset values
      do_reset();
      chk("rst_pc", ifa.pc, 8'h00);
      chk("rst_addr", ifa.ram_addr, 8'h00);
      chk("rst_ir", ifa.ir, 8'h00);
      chk("rst_state", ifa.state, 2'd0);
      chk("rst_rd", ifa.ram_rd, 1'b0);
      chk("rst_ex", ifa.exec_strobe, 1'b0);
      chk("rst_halt", ifa.halt, 1'b0);
      chk("rst_cnt", ifa.instr_count, 8'h00);
      chk("rstpc_ff_pc", ifb.pc, 8'hFF);

      // pc wrap from RESET_PC=0xFF
      pulse(1, 0, 0, 0);
      chk("wrap_addr", ifb.ram_addr, 8'hFF);
      pulse(0, 1, 0, 0);
      pulse(0, 0, 1, 0);
      chk("wrap_pc", ifb.pc, 8'h00);
      chk("wrap_ir", ifb.ir, 8'h00);

      // NOP x3 then JMP 0x0A, one row per machine cycle
      do_reset();
      for (int r = 0; r < 17; r++) begin
         machine_cycle(rd_s, ex_s);
         chk($sformatf("row%0d_state", r), ifa.state, tbl[r].st);
         chk($sformatf("row%0d_pc", r), ifa.pc, tbl[r].pc);
         chk($sformatf("row%0d_cnt", r), ifa.instr_count, tbl[r].cnt);
         chk($sformatf("row%0d_addr", r), ifa.ram_addr, tbl[r].addr);
         chk($sformatf("row%0d_rd", r), rd_s, tbl[r].rd);
         chk($sformatf("row%0d_ex", r), ex_s, tbl[r].ex);
         chk($sformatf("row%0d_rd_drop", r), ifa.ram_rd, 1'b0);
         chk($sformatf("row%0d_ex_drop", r), ifa.exec_strobe, 1'b0);
      end

      // all phases at once: only internal_clk acts
      do_reset();
      pulse(1, 1, 1, 0);
      chk("prio_state", ifa.state, 2'd1);
      chk("prio_pc", ifa.pc, 8'h01);
      chk("prio_rd", ifa.ram_rd, 1'b0);

      // resume while not halted does nothing
      do_reset();
      pulse(0, 0, 0, 1);
      chk("res_nohalt_halt", ifa.halt, 1'b0);
      chk("res_nohalt_state", ifa.state, 2'd0);

      // HALT at address 0
      mem[0] = 8'hF0;
      machine_cycle(rd_s, ex_s);
      machine_cycle(rd_s, ex_s);
      chk("halt_halt", ifa.halt, 1'b1);
      chk("halt_state", ifa.state, 2'd0);
      chk("halt_pc", ifa.pc, 8'h01);
      chk("halt_cnt", ifa.instr_count, 8'h01);
      pulse(1, 0, 0, 0);
      repeat (20) step();
      pulse(0, 1, 0, 0);
      chk("halted_rd", ifa.ram_rd, 1'b0);
      pulse(0, 0, 1, 0);
      chk("halted_halt", ifa.halt, 1'b1);
      chk("halted_pc", ifa.pc, 8'h01);
      chk("halted_cnt", ifa.instr_count, 8'h01);
      chk("halted_state", ifa.state, 2'd0);
      chk("halted_addr", ifa.ram_addr, 8'h00);
      chk("halted_ir", ifa.ir, 8'hF0);

      // resume coincident with cycle_clk: resume wins
      pulse(1, 0, 0, 1);
      chk("resume_halt", ifa.halt, 1'b0);
      chk("resume_pc", ifa.pc, 8'h01);
      chk("resume_addr", ifa.ram_addr, 8'h00);
      pulse(1, 0, 0, 0);
      chk("post_resume_addr", ifa.ram_addr, 8'h01);

      // reset between ram_clk and internal_clk of FETCH
      pulse(0, 1, 0, 0);
      chk("mid_rd_set", ifa.ram_rd, 1'b1);
      #2 reset = 1'b0;
      #1;
      chk("mid_rst_rd", ifa.ram_rd, 1'b0);
      chk("mid_rst_state", ifa.state, 2'd0);
      chk("mid_rst_pc", ifa.pc, 8'h00);
      chk("mid_rst_addr", ifa.ram_addr, 8'h00);
      chk("mid_rst_ir", ifa.ir, 8'h00);
      chk("mid_rst_cnt", ifa.instr_count, 8'h00);
      chk("mid_rst_halt", ifa.halt, 1'b0);
      step();
      reset = 1'b1;
      mem[0] = 8'h00;
      pulse(1, 1, 0, 0);
      pulse(1, 0, 0, 0);
      chk("refetch_addr", ifa.ram_addr, 8'h00);
      pulse(0, 1, 0, 0);
      chk("refetch_rd", ifa.ram_rd, 1'b1);
      pulse(0, 0, 1, 0);
      chk("refetch_pc", ifa.pc, 8'h01);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule

// File: doc/cycle_sequencer.md
Name: cycle_sequencer

Overview:
Fetch/decode/execute/writeback control stage driven by the three phase pulses of the clock stage: cycle_clk, then ram_clk, then internal_clk, repeating.
- One machine cycle is one cycle_clk/ram_clk/internal_clk triple.
- One instruction takes four machine cycles.
- Owns the program counter, instruction register and RAM read strobe.
- Raises halt back to the clock stage on a HALT opcode and clears it on resume.

Parameters:
ADDR_W, 8, program counter / RAM address width
DATA_W, 8, RAM data and instruction register width
OPC_W, 4, opcode width (opcode = ir[DATA_W-1 -: OPC_W], operand = ir[DATA_W-OPC_W-1:0])
HALT_OPC, 4'hF, opcode that stops the machine
JMP_OPC, 4'h1, opcode that loads pc from operand
RESET_PC, 0, pc value after reset

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset
cycle_clk  in  1  phase pulse: machine-cycle start
ram_clk  in  1  phase pulse: RAM access
internal_clk  in  1  phase pulse: latch/commit
resume  in  1  single-cycle pulse, clears halt
ram_rdata  in  DATA_W  RAM read data, combinational from ram_addr
ram_addr  out  ADDR_W  RAM address
ram_rd  out  1  RAM read strobe
exec_strobe  out  1  execute-unit enable pulse
ir  out  DATA_W  instruction register
pc  out  ADDR_W  program counter
state  out  2  0=FETCH 1=DECODE 2=EXECUTE 3=WRITEBACK
halt  out  1  stop request to clock stage
instr_count  out  8  retired-instruction counter

Behaviour:
- Reset (reset=0, asynchronous, immediate):
  - pc=RESET_PC; ram_addr=0; ir=0; state=FETCH.
  - ram_rd=0; exec_strobe=0; halt=0; instr_count=0.
- All outputs are registered. A "phase X event" means a clk edge at which input X=1 and halt=0.
- Phase priority if several phases are high at once (illegal upstream): internal_clk > ram_clk > cycle_clk. Only the highest is acted on.
- FETCH:
  - cycle_clk: ram_addr<=pc.
  - ram_clk: ram_rd<=1. ram_rd is therefore high for exactly the clk cycle in which internal_clk is high.
  - internal_clk: ir<=ram_rdata; pc<=pc+1 mod 2^ADDR_W (0xFF wraps to 0x00); state<=DECODE.
- DECODE:
  - internal_clk with opcode==HALT_OPC: halt<=1, state<=FETCH. The instruction retires (instr_count+1).
  - internal_clk otherwise: state<=EXECUTE.
- EXECUTE:
  - ram_clk: exec_strobe<=1 for one clk.
  - internal_clk: if opcode==JMP_OPC, pc<=zero-extended operand. state<=WRITEBACK.
- WRITEBACK:
  - internal_clk: state<=FETCH; instr_count<=instr_count+1, wrapping 0xFF->0x00.
- ram_rd and exec_strobe clear on the next edge after being set; they never stay high for 2 cycles.
- Halt:
  - While halt=1, all phase inputs are ignored. This covers the stray cycle_clk the clock stage emits in the cycle after halt rises.
  - pc, ir and instr_count hold their values.
- resume=1 with halt=1: halt<=0 and state=FETCH. Any phase pulse in that same cycle is ignored (resume wins).
- resume with halt=0 has no effect.
- Reset mid-instruction: state returns to FETCH and a partial ram_rd/exec_strobe drops at once. No retire is counted.

Test Plan:
1. RAM[0..3]=0x00 (NOP), 12 machine cycles of phases -> state goes 0,1,2,3 per instruction; instr_count=3; pc=3. Each ram_rd is high 1 clk, coincident with internal_clk, with ram_addr=0,1,2.
2. RESET_PC=0xFF, RAM[0xFF]=0x00 -> after fetch pc=0x00, ram_addr was 0xFF; no X on pc.
3. RAM[0]=0xF0 -> halt=1 after DECODE internal_clk; state=FETCH; pc=1; instr_count=1. A further cycle_clk pulse plus 20 idle cycles -> no change in any output.
4. From 3, resume pulse coincident with cycle_clk -> halt=0, pc=1, ram_addr unchanged that cycle. Next cycle_clk loads ram_addr=1.
5. RAM[0]=0x1A -> exec_strobe pulses once in EXECUTE; pc=0x0A after EXECUTE internal_clk; next fetch ram_addr=0x0A.
6. Assert reset low between ram_clk and internal_clk of FETCH -> ram_rd=0 immediately; all outputs at reset values; after release, first fetch uses ram_addr=RESET_PC.
